// File: rtl/lcd_spi_capture.sv
// Purpose: snoops a write-only LCD SPI link, decodes CASET/RASET/RAMWR and emits pixels with screen coordinates.
// Latency: cmd_valid / pix_valid / window_err rise 4 clk_50MHz cycles after the 8th sclk rising edge at the pins.
// Backpressure: none; the bus is observed passively and every output is a single-cycle pulse.
// Ports: clk_50MHz, rst_n (async, active low); lcd_cs/lcd_sclk/lcd_mosi/lcd_dc (async SPI pins);
//        cmd_valid/cmd_byte (command seen), pix_valid/pix_x/pix_y/pix_data/frame_done (pixel stream),
//        window_err (CASET/RASET parameter set rejected).
module lcd_spi_capture #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       lcd_cs,
    input  logic       lcd_sclk,
    input  logic       lcd_mosi,
    input  logic       lcd_dc,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       pix_valid,
    output logic [8:0] pix_x,
    output logic [8:0] pix_y,
    output logic [7:0] pix_data,
    output logic       frame_done,
    output logic       window_err
);

    localparam logic [9:0] H_LIM = 10'(H_RES);
    localparam logic [9:0] V_LIM = 10'(V_RES);

    typedef enum logic [2:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR, S_OTHER} state_t;

    // ---------------- pin synchronizers and byte framing ----------------
    logic [1:0] cs_sr, sclk_sr, mosi_sr, dc_sr;
    logic       sclk_d, cs_d;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       byte_vld, byte_dc;
    logic [7:0] byte_dat;

    logic cs_s, sclk_s, mosi_s, dc_s, sclk_rise, shift_en;
    assign cs_s      = cs_sr[1];
    assign sclk_s    = sclk_sr[1];
    assign mosi_s    = mosi_sr[1];
    assign dc_s      = dc_sr[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    // cs_d still low means the select was active until this cycle, so an
    // sclk edge arriving together with the cs rise still counts.
    assign shift_en  = sclk_rise & ~(cs_s & cs_d);

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            cs_sr    <= 2'b11;
            sclk_sr  <= 2'b00;
            mosi_sr  <= 2'b00;
            dc_sr    <= 2'b00;
            sclk_d   <= 1'b0;
            cs_d     <= 1'b1;
            bit_cnt  <= 3'd0;
            shreg    <= 7'd0;
            byte_vld <= 1'b0;
            byte_dc  <= 1'b0;
            byte_dat <= 8'd0;
        end else begin
            cs_sr    <= {cs_sr[0], lcd_cs};
            sclk_sr  <= {sclk_sr[0], lcd_sclk};
            mosi_sr  <= {mosi_sr[0], lcd_mosi};
            dc_sr    <= {dc_sr[0], lcd_dc};
            sclk_d   <= sclk_s;
            cs_d     <= cs_s;
            byte_vld <= 1'b0;
            if (shift_en) begin
                shreg   <= {shreg[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_vld <= 1'b1;
                    byte_dat <= {shreg, mosi_s};
                    byte_dc  <= dc_s;
                end
            end
            // Deselect always drops any partial byte; placed last so it wins.
            if (cs_s) bit_cnt <= 3'd0;
        end
    end

    // ---------------- command decoder ----------------
    state_t     state_q, state_d;
    logic [1:0] p_idx;
    logic       p_done, p_hi;
    logic [8:0] p_start, p_end;
    logic [8:0] xs, xe, ys, ye, ptr_x, ptr_y;
    logic       win_bad;

    assign p_end   = {p_hi, byte_dat};
    assign win_bad = (p_start > p_end) ||
                     ((state_q == S_CASET) ? ({1'b0, p_end} >= H_LIM)
                                           : ({1'b0, p_end} >= V_LIM));

    always_comb begin
        state_d = state_q;
        if (byte_vld && !byte_dc) begin
            case (byte_dat)
                8'h2A:   state_d = S_CASET;
                8'h2B:   state_d = S_RASET;
                8'h2C:   state_d = S_RAMWR;
                default: state_d = S_OTHER;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid  <= 1'b0;
            cmd_byte   <= 8'h00;
            pix_valid  <= 1'b0;
            pix_x      <= 9'd0;
            pix_y      <= 9'd0;
            pix_data   <= 8'd0;
            frame_done <= 1'b0;
            window_err <= 1'b0;
            p_idx      <= 2'd0;
            p_done     <= 1'b0;
            p_hi       <= 1'b0;
            p_start    <= 9'd0;
            xs         <= 9'd0;
            xe         <= 9'(H_RES - 1);
            ys         <= 9'd0;
            ye         <= 9'(V_RES - 1);
            ptr_x      <= 9'd0;
            ptr_y      <= 9'd0;
        end else begin
            cmd_valid  <= 1'b0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            window_err <= 1'b0;
            if (byte_vld && !byte_dc) begin
                cmd_valid <= 1'b1;
                cmd_byte  <= byte_dat;
                p_idx     <= 2'd0;
                p_done    <= 1'b0;
                if (byte_dat == 8'h2C) begin
                    ptr_x <= xs;
                    ptr_y <= ys;
                end
            end else if (byte_vld) begin
                case (state_q)
                    S_CASET, S_RASET: begin
                        if (!p_done) begin
                            p_idx <= p_idx + 2'd1;
                            case (p_idx)
                                2'd1: p_start <= {p_hi, byte_dat};
                                2'd3: begin
                                    p_done <= 1'b1;
                                    if (win_bad) begin
                                        window_err <= 1'b1;
                                    end else if (state_q == S_CASET) begin
                                        xs <= p_start;
                                        xe <= p_end;
                                    end else begin
                                        ys <= p_start;
                                        ye <= p_end;
                                    end
                                end
                                // Only bit 0 of a high byte survives into the 9-bit coordinate.
                                default: p_hi <= byte_dat[0];
                            endcase
                        end
                    end
                    S_RAMWR: begin
                        pix_valid <= 1'b1;
                        pix_x     <= ptr_x;
                        pix_y     <= ptr_y;
                        pix_data  <= byte_dat;
                        if (ptr_x == xe && ptr_y == ye) begin
                            frame_done <= 1'b1;
                            ptr_x      <= xs;
                            ptr_y      <= ys;
                        end else if (ptr_x == xe) begin
                            ptr_x <= xs;
                            ptr_y <= ptr_y + 9'd1;
                        end else begin
                            ptr_x <= ptr_x + 9'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
